// File: rtl/wavelet_pkg.sv
// wavelet_pkg
// Shared definitions for the wavelet_core host-side job sequencer:
// driver state encoding, default widths and the input-length decode.
package wavelet_pkg;

    localparam int unsigned DEF_INPUT_WIDTH      = 32;
    localparam int unsigned DEF_IBUFF_CELL_COUNT = 2048;
    localparam int unsigned DEF_OBUFF_CELL_COUNT = 4096;
    localparam int unsigned DEF_MAX_FILTER_SIZE  = 32;
    localparam int unsigned NCNT_WIDTH           = 12;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        LOAD,
        RUN,
        DONE
    } drv_state_t;

    // Input samples per job: 256 << len (256, 512, 1024, 2048).
    function automatic logic [NCNT_WIDTH-1:0] input_count(input logic [1:0] len);
        return NCNT_WIDTH'(256) << len;
    endfunction

endpackage

// File: rtl/wavelet_out_skid.sv
// wavelet_out_skid
// One-entry output register between the core pop strobe and the m_* stream.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   push, push_data word popped from the core this cycle
//   m_data/m_valid  held word, valid while the register is occupied
//   m_ready         downstream consume; a push on the consume cycle refills
module wavelet_out_skid
    import wavelet_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_INPUT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        valid_d = push | (valid_q & ~m_ready);
        data_d  = push ? push_data : data_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign m_valid = valid_q;
    assign m_data  = data_q;

endmodule

// File: rtl/wavelet_core_driver.sv
// wavelet_core_driver
// Runs one wavelet_core job per accepted start: latch cfg, reset the core
// read pointer, init the core, stream N input samples in, raise go, then
// drain cfg_out_count output words into the m_* stream.
// Ports:
//   clk, rst                   clock, synchronous active-low reset
//   start / busy / done        job request, in-progress flag, end pulse
//   cfg_*                      job configuration, sampled on start
//   s_*                        input sample stream (valid/ready)
//   m_*                        output word stream (valid/ready)
//   core_*                     register interface of wavelet_core
//   clear_core_init/_go        core acknowledges of init / go
module wavelet_core_driver
    import wavelet_pkg::*;
#(
    parameter int unsigned INPUT_WIDTH      = DEF_INPUT_WIDTH,
    parameter int unsigned IBUFF_CELL_COUNT = DEF_IBUFF_CELL_COUNT,
    parameter int unsigned OBUFF_CELL_COUNT = DEF_OBUFF_CELL_COUNT,
    parameter int unsigned MAX_FILTER_SIZE  = DEF_MAX_FILTER_SIZE,
    parameter int unsigned FS_WIDTH         = $clog2(MAX_FILTER_SIZE),
    parameter int unsigned OCNT_WIDTH       = $clog2(OBUFF_CELL_COUNT) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    input  logic [FS_WIDTH-1:0]    cfg_filter_size,
    input  logic [1:0]             cfg_dec_level,
    input  logic [1:0]             cfg_inputs_len,
    input  logic                   cfg_downsample,
    input  logic [OCNT_WIDTH-1:0]  cfg_out_count,
    input  logic [INPUT_WIDTH-1:0] s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic [INPUT_WIDTH-1:0] m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [INPUT_WIDTH-1:0] core_data_in,
    output logic                   core_input_reg_en,
    output logic                   core_init,
    output logic                   core_go,
    input  logic                   clear_core_init,
    input  logic                   clear_core_go,
    output logic [FS_WIDTH-1:0]    core_filter_size,
    output logic [1:0]             core_dec_level,
    output logic [1:0]             core_inputs_len,
    output logic                   core_downsample,
    output logic                   core_r_addr_rst,
    input  logic [INPUT_WIDTH-1:0] core_data_out,
    input  logic                   core_r_data_available,
    output logic                   core_output_reg_en_pulse
);

    localparam int unsigned ICNT_WIDTH = $clog2(IBUFF_CELL_COUNT) + 1;

    drv_state_t            state_q, state_d;
    logic [FS_WIDTH-1:0]   filter_size_q, filter_size_d;
    logic [1:0]            dec_level_q, dec_level_d;
    logic [1:0]            inputs_len_q, inputs_len_d;
    logic                  downsample_q, downsample_d;
    logic [OCNT_WIDTH-1:0] out_count_q, out_count_d;
    logic [ICNT_WIDTH-1:0] in_cnt_q, in_cnt_d;
    logic [OCNT_WIDTH-1:0] pop_cnt_q, pop_cnt_d;
    logic                  go_ack_q, go_ack_d;
    logic                  r_addr_rst_q, r_addr_rst_d;

    logic                  pop;
    logic                  skid_valid;
    logic [NCNT_WIDTH-1:0] in_last;

    assign in_last = input_count(inputs_len_q) - NCNT_WIDTH'(1);

    // Pop only when the skid register can take the word this cycle.
    assign pop = (state_q == RUN) && core_r_data_available &&
                 (!skid_valid || m_ready) && (pop_cnt_q < out_count_q);

    always_comb begin
        state_d       = state_q;
        filter_size_d = filter_size_q;
        dec_level_d   = dec_level_q;
        inputs_len_d  = inputs_len_q;
        downsample_d  = downsample_q;
        out_count_d   = out_count_q;
        in_cnt_d      = in_cnt_q;
        pop_cnt_d     = pop_cnt_q;
        go_ack_d      = go_ack_q;
        r_addr_rst_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d       = INIT;
                    filter_size_d = cfg_filter_size;
                    dec_level_d   = cfg_dec_level;
                    inputs_len_d  = cfg_inputs_len;
                    downsample_d  = cfg_downsample;
                    out_count_d   = cfg_out_count;
                    in_cnt_d      = '0;
                    pop_cnt_d     = '0;
                    go_ack_d      = 1'b0;
                    r_addr_rst_d  = 1'b1;
                end
            end
            INIT: begin
                if (clear_core_init) state_d = LOAD;
            end
            LOAD: begin
                if (s_valid) begin
                    if (in_cnt_q == ICNT_WIDTH'(in_last)) state_d = RUN;
                    else                                  in_cnt_d = in_cnt_q + ICNT_WIDTH'(1);
                end
            end
            RUN: begin
                if (clear_core_go) go_ack_d = 1'b1;
                if (pop) pop_cnt_d = pop_cnt_q + OCNT_WIDTH'(1);
                if (go_ack_q && (pop_cnt_q == out_count_q) && !skid_valid) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            filter_size_q <= '0;
            dec_level_q   <= '0;
            inputs_len_q  <= '0;
            downsample_q  <= 1'b0;
            out_count_q   <= '0;
            in_cnt_q      <= '0;
            pop_cnt_q     <= '0;
            go_ack_q      <= 1'b0;
            r_addr_rst_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            filter_size_q <= filter_size_d;
            dec_level_q   <= dec_level_d;
            inputs_len_q  <= inputs_len_d;
            downsample_q  <= downsample_d;
            out_count_q   <= out_count_d;
            in_cnt_q      <= in_cnt_d;
            pop_cnt_q     <= pop_cnt_d;
            go_ack_q      <= go_ack_d;
            r_addr_rst_q  <= r_addr_rst_d;
        end
    end

    wavelet_out_skid #(
        .WIDTH (INPUT_WIDTH)
    ) u_out_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (pop),
        .push_data (core_data_out),
        .m_data    (m_data),
        .m_valid   (skid_valid),
        .m_ready   (m_ready)
    );

    assign m_valid                  = skid_valid;
    assign busy                     = (state_q != IDLE);
    assign done                     = (state_q == DONE);
    assign core_init                = (state_q == INIT);
    assign core_go                  = (state_q == RUN) && !go_ack_q;
    assign s_ready                  = (state_q == LOAD);
    assign core_input_reg_en        = s_ready && s_valid;
    assign core_data_in             = s_ready ? s_data : '0;
    assign core_r_addr_rst          = r_addr_rst_q;
    assign core_output_reg_en_pulse = pop;
    assign core_filter_size         = filter_size_q;
    assign core_dec_level           = dec_level_q;
    assign core_inputs_len          = inputs_len_q;
    assign core_downsample          = downsample_q;

endmodule

// File: tb/tb_wavelet_core_driver.sv
module tb_wavelet_core_driver;

    localparam int W   = 32;
    localparam int FSW = 5;
    localparam int OCW = 13;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           busy, done;
    logic [FSW-1:0] cfg_filter_size;
    logic [1:0]     cfg_dec_level, cfg_inputs_len;
    logic           cfg_downsample;
    logic [OCW-1:0] cfg_out_count;
    logic [W-1:0]   s_data;
    logic           s_valid, s_ready;
    logic [W-1:0]   m_data;
    logic           m_valid, m_ready;
    logic [W-1:0]   core_data_in;
    logic           core_input_reg_en, core_init, core_go;
    logic           clear_core_init, clear_core_go;
    logic [FSW-1:0] core_filter_size;
    logic [1:0]     core_dec_level, core_inputs_len;
    logic           core_downsample, core_r_addr_rst;
    logic [W-1:0]   core_data_out;
    logic           core_r_data_available, core_output_reg_en_pulse;

    always #5 clk = ~clk;

    wavelet_core_driver #(
        .INPUT_WIDTH      (32),
        .IBUFF_CELL_COUNT (2048),
        .OBUFF_CELL_COUNT (4096),
        .MAX_FILTER_SIZE  (32)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .start                    (start),
        .busy                     (busy),
        .done                     (done),
        .cfg_filter_size          (cfg_filter_size),
        .cfg_dec_level            (cfg_dec_level),
        .cfg_inputs_len           (cfg_inputs_len),
        .cfg_downsample           (cfg_downsample),
        .cfg_out_count            (cfg_out_count),
        .s_data                   (s_data),
        .s_valid                  (s_valid),
        .s_ready                  (s_ready),
        .m_data                   (m_data),
        .m_valid                  (m_valid),
        .m_ready                  (m_ready),
        .core_data_in             (core_data_in),
        .core_input_reg_en        (core_input_reg_en),
        .core_init                (core_init),
        .core_go                  (core_go),
        .clear_core_init          (clear_core_init),
        .clear_core_go            (clear_core_go),
        .core_filter_size         (core_filter_size),
        .core_dec_level           (core_dec_level),
        .core_inputs_len          (core_inputs_len),
        .core_downsample          (core_downsample),
        .core_r_addr_rst          (core_r_addr_rst),
        .core_data_out            (core_data_out),
        .core_r_data_available    (core_r_data_available),
        .core_output_reg_en_pulse (core_output_reg_en_pulse)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Source model: sequential sample values, optional gap every third cycle.
    logic        feed_en = 1'b0;
    logic        feed_clr = 1'b0;
    logic        gap_mode = 1'b0;
    logic [31:0] feed_idx = '0;
    int unsigned cyc = 0;
    assign s_valid = feed_en && !(gap_mode && (cyc % 3 == 0));
    assign s_data  = feed_idx;

    // Core output model: 12 words available, value A000_0000 + index.
    logic        avail_en = 1'b0;
    logic        core_clr = 1'b0;
    logic [31:0] rd_idx = '0;
    assign core_r_data_available = avail_en && (rd_idx < 32'd12);
    assign core_data_out         = 32'hA000_0000 + rd_idx;

    // Sink model: fixed or toggling ready.
    logic mr_toggle = 1'b0;
    logic mr_t = 1'b0;
    logic mr_fixed = 1'b0;
    assign m_ready = mr_toggle ? mr_t : mr_fixed;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (feed_clr) feed_idx <= '0;
        else if (s_valid && s_ready) feed_idx <= feed_idx + 32'd1;
        if (core_clr) rd_idx <= '0;
        else if (core_output_reg_en_pulse) rd_idx <= rd_idx + 32'd1;
        if (mr_toggle) mr_t <= ~mr_t;
    end

    // Per-cycle observation counters, sampled mid-cycle.
    int          wr_count = 0;
    int          order_err = 0;
    int          early_wr = 0;
    int          pop_count = 0;
    int          pop_unavail = 0;
    int          pop_overrun = 0;
    int          rx_count = 0;
    int          done_count = 0;
    logic [31:0] rx [0:15];

    always @(negedge clk) begin
        if (core_input_reg_en) begin
            if (core_data_in !== 32'(wr_count)) order_err++;
            if (core_init) early_wr++;
            wr_count++;
        end
        if (core_output_reg_en_pulse) begin
            pop_count++;
            if (!core_r_data_available) pop_unavail++;
            if (m_valid && !m_ready) pop_overrun++;
        end
        if (m_valid && m_ready) begin
            if (rx_count < 16) rx[rx_count] = m_data;
            rx_count++;
        end
        if (done) done_count++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_job(input logic [FSW-1:0] fs, input logic [1:0] dl,
                             input logic [1:0] len, input logic ds, input logic [OCW-1:0] oc);
        cfg_filter_size = fs;
        cfg_dec_level   = dl;
        cfg_inputs_len  = len;
        cfg_downsample  = ds;
        cfg_out_count   = oc;
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic clear_counters();
        wr_count = 0; order_err = 0; early_wr = 0; pop_count = 0;
        pop_unavail = 0; pop_overrun = 0; rx_count = 0; done_count = 0;
    endtask

    task automatic test_reset();
        logic [9:0] ctl;
        rst = 1'b0;
        feed_en = 1'b1;
        avail_en = 1'b1;
        mr_fixed = 1'b1;
        cfg_filter_size = 5'd17;
        step(3);
        ctl = {busy, done, core_init, core_go, s_ready, core_input_reg_en,
               core_r_addr_rst, core_output_reg_en_pulse, m_valid, core_downsample};
        n_cmp++;
        if (ctl !== 10'b0) begin
            $display("FAIL reset_ctl: got %b want %b", ctl, 10'b0);
            n_err++;
        end
        n_cmp++;
        if (core_data_in !== 32'd0) begin
            $display("FAIL reset_data_in: got %h want %h", core_data_in, 32'd0);
            n_err++;
        end
        n_cmp++;
        if ({core_filter_size, core_dec_level, core_inputs_len} !== 9'd0) begin
            $display("FAIL reset_cfg: got %h want 0", {core_filter_size, core_dec_level, core_inputs_len});
            n_err++;
        end
        feed_en = 1'b0;
        avail_en = 1'b0;
        mr_fixed = 1'b0;
        rst = 1'b1;
        step(1);
    endtask

    task automatic test_load_len0();
        int k;
        clear_counters();
        feed_en = 1'b1;
        start_job(5'd7, 2'd2, 2'd0, 1'b1, 13'd0);
        n_cmp++;
        if ({busy, core_r_addr_rst, core_init} !== 3'b111) begin
            $display("FAIL start_t1: busy/rst/init got %b want 111", {busy, core_r_addr_rst, core_init});
            n_err++;
        end
        n_cmp++;
        if ({core_filter_size, core_dec_level, core_inputs_len, core_downsample} !== {5'd7, 2'd2, 2'd0, 1'b1}) begin
            $display("FAIL cfg_latch: got %h want %h", {core_filter_size, core_dec_level, core_inputs_len, core_downsample},
                     {5'd7, 2'd2, 2'd0, 1'b1});
            n_err++;
        end
        step(1);
        n_cmp++;
        if (core_r_addr_rst !== 1'b0) begin
            $display("FAIL addr_rst_pulse: got %b want 0", core_r_addr_rst);
            n_err++;
        end
        step(4);
        n_cmp++;
        if ({core_init, 32'(wr_count)} !== {1'b1, 32'd0}) begin
            $display("FAIL init_hold: init=%b writes=%0d want init=1 writes=0", core_init, wr_count);
            n_err++;
        end
        clear_core_init = 1'b1;
        step(1);
        clear_core_init = 1'b0;
        n_cmp++;
        if ({core_init, s_ready} !== 2'b01) begin
            $display("FAIL init_ack: init/s_ready got %b want 01", {core_init, s_ready});
            n_err++;
        end
        for (k = 0; k < 400 && !core_go; k++) step(1);
        n_cmp++;
        if (core_go !== 1'b1) begin
            $display("FAIL go_timeout: core_go got %b want 1", core_go);
            n_err++;
        end
        n_cmp++;
        if (wr_count !== 256) begin
            $display("FAIL len0_writes: got %0d want 256", wr_count);
            n_err++;
        end
        n_cmp++;
        if ({order_err, early_wr} !== {32'd0, 32'd0}) begin
            $display("FAIL len0_order: order_err=%0d early_wr=%0d want 0 0", order_err, early_wr);
            n_err++;
        end
        feed_en = 1'b0;
        step(3);
        n_cmp++;
        if ({core_go, busy, done} !== 3'b110) begin
            $display("FAIL go_hold: go/busy/done got %b want 110", {core_go, busy, done});
            n_err++;
        end
        clear_core_go = 1'b1;
        step(1);
        clear_core_go = 1'b0;
        n_cmp++;
        if (core_go !== 1'b0) begin
            $display("FAIL go_ack: core_go got %b want 0", core_go);
            n_err++;
        end
        step(1);
        n_cmp++;
        if (done !== 1'b1) begin
            $display("FAIL done_zero_count: done got %b want 1", done);
            n_err++;
        end
        step(1);
        n_cmp++;
        if ({busy, done, 32'(done_count), 32'(pop_count)} !== {2'b00, 32'd1, 32'd0}) begin
            $display("FAIL end_len0: busy=%b done=%b dones=%0d pops=%0d want 0 0 1 0", busy, done, done_count, pop_count);
            n_err++;
        end
    endtask

    task automatic test_drain();
        int k;
        feed_clr = 1'b1;
        core_clr = 1'b1;
        step(1);
        feed_clr = 1'b0;
        core_clr = 1'b0;
        clear_counters();
        feed_en = 1'b1;
        start_job(5'd9, 2'd1, 2'd0, 1'b0, 13'd10);
        clear_core_init = 1'b1;
        step(1);
        clear_core_init = 1'b0;
        for (k = 0; k < 400 && !core_go; k++) step(1);
        feed_en = 1'b0;
        mr_fixed = 1'b1;
        step(3);
        n_cmp++;
        if ({core_go, 32'(pop_count), m_valid} !== {1'b1, 32'd0, 1'b0}) begin
            $display("FAIL no_avail: go=%b pops=%0d m_valid=%b want 1 0 0", core_go, pop_count, m_valid);
            n_err++;
        end
        cfg_filter_size = 5'd31;
        cfg_out_count = 13'd3;
        start = 1'b1;
        step(1);
        start = 1'b0;
        n_cmp++;
        if ({core_filter_size, core_r_addr_rst, busy, core_go} !== {5'd9, 1'b0, 1'b1, 1'b1}) begin
            $display("FAIL start_in_run: fs=%0d addr_rst=%b busy=%b go=%b want 9 0 1 1",
                     core_filter_size, core_r_addr_rst, busy, core_go);
            n_err++;
        end
        mr_toggle = 1'b1;
        avail_en = 1'b1;
        for (k = 0; k < 200 && !(rx_count == 10 && !m_valid); k++) step(1);
        step(5);
        n_cmp++;
        if ({32'(pop_count), 32'(rx_count), rd_idx} !== {32'd10, 32'd10, 32'd10}) begin
            $display("FAIL drain_count: pops=%0d rx=%0d rd_idx=%0d want 10 10 10", pop_count, rx_count, rd_idx);
            n_err++;
        end
        n_cmp++;
        if ({busy, core_go, 32'(done_count)} !== {1'b1, 1'b1, 32'd0}) begin
            $display("FAIL wait_go_ack: busy=%b go=%b dones=%0d want 1 1 0", busy, core_go, done_count);
            n_err++;
        end
        n_cmp++;
        if ({pop_overrun, pop_unavail} !== {32'd0, 32'd0}) begin
            $display("FAIL pop_rules: overrun=%0d unavail=%0d want 0 0", pop_overrun, pop_unavail);
            n_err++;
        end
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (rx[i] !== 32'hA000_0000 + 32'(i)) begin
                $display("FAIL drain_word[%0d]: got %h want %h", i, rx[i], 32'hA000_0000 + 32'(i));
                n_err++;
            end
        end
        clear_core_go = 1'b1;
        step(1);
        clear_core_go = 1'b0;
        for (k = 0; k < 10 && done_count == 0; k++) step(1);
        step(2);
        n_cmp++;
        if ({32'(done_count), busy} !== {32'd1, 1'b0}) begin
            $display("FAIL drain_done: dones=%0d busy=%b want 1 0", done_count, busy);
            n_err++;
        end
        mr_toggle = 1'b0;
        mr_fixed = 1'b0;
        avail_en = 1'b0;
    endtask

    task automatic test_abort_midload();
        int k;
        feed_clr = 1'b1;
        step(1);
        feed_clr = 1'b0;
        clear_counters();
        feed_en = 1'b1;
        gap_mode = 1'b1;
        start_job(5'd3, 2'd3, 2'd0, 1'b1, 13'd0);
        clear_core_init = 1'b1;
        step(1);
        clear_core_init = 1'b0;
        for (k = 0; k < 400 && wr_count < 100; k++) step(1);
        rst = 1'b0;
        step(1);
        n_cmp++;
        if ({busy, s_ready, core_input_reg_en, core_init, core_go, done} !== 6'b0) begin
            $display("FAIL abort_ctl: got %b want 000000",
                     {busy, s_ready, core_input_reg_en, core_init, core_go, done});
            n_err++;
        end
        n_cmp++;
        if ({core_filter_size, core_dec_level, core_downsample} !== 8'd0) begin
            $display("FAIL abort_cfg: got %h want 0", {core_filter_size, core_dec_level, core_downsample});
            n_err++;
        end
        rst = 1'b1;
        feed_clr = 1'b1;
        step(1);
        feed_clr = 1'b0;
        clear_counters();
        start_job(5'd3, 2'd3, 2'd0, 1'b1, 13'd0);
        n_cmp++;
        if ({core_r_addr_rst, core_init} !== 2'b11) begin
            $display("FAIL restart_rst: addr_rst/init got %b want 11", {core_r_addr_rst, core_init});
            n_err++;
        end
        clear_core_init = 1'b1;
        step(1);
        clear_core_init = 1'b0;
        for (k = 0; k < 1000 && !core_go; k++) step(1);
        n_cmp++;
        if ({32'(wr_count), 32'(order_err), core_go} !== {32'd256, 32'd0, 1'b1}) begin
            $display("FAIL reload: writes=%0d order_err=%0d go=%b want 256 0 1", wr_count, order_err, core_go);
            n_err++;
        end
        feed_en = 1'b0;
        gap_mode = 1'b0;
        clear_core_go = 1'b1;
        step(1);
        clear_core_go = 1'b0;
        for (k = 0; k < 10 && busy; k++) step(1);
        n_cmp++;
        if ({32'(done_count), busy} !== {32'd1, 1'b0}) begin
            $display("FAIL reload_done: dones=%0d busy=%b want 1 0", done_count, busy);
            n_err++;
        end
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        cfg_filter_size = '0;
        cfg_dec_level = '0;
        cfg_inputs_len = '0;
        cfg_downsample = 1'b0;
        cfg_out_count = '0;
        clear_core_init = 1'b0;
        clear_core_go = 1'b0;
        test_reset();
        test_load_len0();
        test_drain();
        test_abort_midload();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
